// File: rtl/bus_check_arbiter.sv
// Round-robin arbiter sharing one word-checker among NUM_REQ requesters.
// Tracks per-requester saturating error counts; a saturated requester is locked out until reset.
module bus_check_arbiter #(
  parameter int unsigned BUS_SIZE  = 16,
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned WORD_NUM  = BUS_SIZE / WORD_SIZE,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CHECK_LAT = 1,
  parameter int unsigned ERR_CNT_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BUS_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [BUS_SIZE-1:0]           data_bus,
  output logic                          bus_valid,
  input  logic [WORD_NUM-1:0]           control_in,
  input  logic                          error_in,
  output logic                          resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [WORD_NUM-1:0]           resp_control,
  output logic                          resp_error,
  output logic [NUM_REQ*ERR_CNT_W-1:0]  err_count,
  output logic                          busy
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned LAT_W = $clog2(CHECK_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t                r_state, w_next;
  logic [ID_W-1:0]       r_ptr, r_gid, w_gnt_id;
  logic                  w_gnt_found, w_grant;
  logic [NUM_REQ-1:0]    w_locked, w_eligible;
  logic [ERR_CNT_W-1:0]  r_err_cnt [NUM_REQ];
  logic [BUS_SIZE-1:0]   w_words   [NUM_REQ];
  logic [LAT_W-1:0]      r_wait_cnt;
  logic [BUS_SIZE-1:0]   r_data_bus;
  logic                  r_resp_valid, r_resp_error;
  logic [ID_W-1:0]       r_resp_id;
  logic [WORD_NUM-1:0]   r_resp_control;
  int unsigned           w_idx;

  always_comb begin
    err_count = '0;
    w_locked  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_words[i] = req_data[i*BUS_SIZE +: BUS_SIZE];
      err_count[i*ERR_CNT_W +: ERR_CNT_W] = r_err_cnt[i];
      w_locked[i] = (r_err_cnt[i] == '1);
    end
  end

  assign w_eligible = req_valid & ~w_locked;

  // First eligible index scanning from the round-robin pointer upward, wrapping.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_gnt_found && w_eligible[w_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = ID_W'(w_idx);
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_gnt_found && !reset;

  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_gnt_id] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_grant) w_next = S_ISSUE;
      S_ISSUE:   w_next = (CHECK_LAT == 1) ? S_CAPTURE : S_WAIT;
      S_WAIT:    if (r_wait_cnt == LAT_W'(1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr          <= '0;
      r_gid          <= '0;
      r_wait_cnt     <= '0;
      r_data_bus     <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_error   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_control <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) r_err_cnt[i] <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_data_bus <= w_words[w_gnt_id];
            r_gid      <= w_gnt_id;
          end
        end
        // WAIT spans CHECK_LAT-1 cycles: load here, leave WAIT when the count reads 1.
        S_ISSUE: r_wait_cnt <= LAT_W'(CHECK_LAT - 1);
        S_WAIT:  r_wait_cnt <= r_wait_cnt - LAT_W'(1);
        S_CAPTURE: begin
          r_resp_valid   <= 1'b1;
          r_resp_id      <= r_gid;
          r_resp_control <= control_in;
          r_resp_error   <= error_in;
          r_ptr          <= (32'(r_gid) == NUM_REQ - 1) ? '0 : r_gid + ID_W'(1);
          if (error_in && r_err_cnt[r_gid] != '1)
            r_err_cnt[r_gid] <= r_err_cnt[r_gid] + ERR_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_bus     = r_data_bus;
  assign bus_valid    = (r_state == S_ISSUE);
  assign busy         = (r_state != S_IDLE);
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_control = r_resp_control;
  assign resp_error   = r_resp_error;

endmodule
